// File: rtl/ram_fifo_ctrl.sv
// FIFO queue controller for an external single-port RAM. Push and pop share the port, with round-robin arbitration.
// Pop data is returned 1 cycle after pop_ready. push_ready and pop_ready drop when the queue is full/empty, when the request loses arbitration, or during flush.
module ram_fifo_ctrl #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop,
  output logic          pop_ready,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ram_wr_en,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          last_pop;
  logic          pop_valid_q;

  logic push_elig;
  logic pop_elig;
  logic contend;
  logic grant_push;
  logic grant_pop;

  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == '0);
  assign push_elig = push & ~full;
  assign pop_elig  = pop & ~empty;
  assign contend   = ~flush & push_elig & pop_elig;

  // On contention the side that did not win last time goes first; flush blocks all access.
  always_comb begin
    grant_push = 1'b0;
    grant_pop  = 1'b0;
    if (!flush) begin
      if (push_elig && pop_elig) begin
        grant_push = last_pop;
        grant_pop  = ~last_pop;
      end else begin
        grant_push = push_elig;
        grant_pop  = pop_elig;
      end
    end
  end

  assign push_ready = grant_push;
  assign pop_ready  = grant_pop;
  assign ram_wr_en  = grant_push;
  assign ram_rd_en  = grant_pop;
  assign ram_add    = grant_push ? wr_ptr : rd_ptr;
  assign ram_din    = grant_push ? push_data : '0;

  assign count     = count_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = ram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      last_pop    <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      // A pop granted just before a flush still reports its data.
      pop_valid_q <= grant_pop;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (grant_push) begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          count_q <= count_q + CNT_ONE;
        end
        if (grant_pop) begin
          rd_ptr  <= rd_ptr + PTR_ONE;
          count_q <= count_q - CNT_ONE;
        end
        if (contend) last_pop <= grant_pop;
      end
    end
  end

endmodule
